// File: rtl/button_conditioner.sv
// Pushbutton conditioner: 2-flop synchronizer, stability-window debounce,
// press/release edge pulses and a hold FSM producing long-press and auto-repeat pulses.
module button_conditioner #(
  parameter int DEB_CYC    = 270000,
  parameter int LONG_CYC   = 27000000,
  parameter int REP_CYC    = 5400000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_btn,
  output logic       o_level,
  output logic       o_press,
  output logic       o_release,
  output logic       o_long,
  output logic       o_repeat,
  output logic [1:0] o_state
);

  localparam int DEB_W    = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam int HOLD_MAX = (LONG_CYC > REP_CYC) ? LONG_CYC : REP_CYC;
  localparam int HOLD_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYC - 1);
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYC - 1);
  localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REP_CYC - 1);

  localparam logic [1:0] ST_RELEASED = 2'd0;
  localparam logic [1:0] ST_HELD     = 2'd1;
  localparam logic [1:0] ST_LONG     = 2'd2;

  logic              sync_p0;
  logic              sync_p1;
  logic [DEB_W-1:0]  deb_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              s;
  logic              settle;
  logic              rise;
  logic              fall;

  // Polarity is normalized after the synchronizer: s = 1 means pressed.
  assign s      = sync_p1 ^ ACTIVE_LOW;
  assign settle = (s != o_level) && (deb_cnt == DEB_LAST);
  assign rise   = settle && !o_level;
  assign fall   = settle && o_level;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_p0   <= ACTIVE_LOW;
      sync_p1   <= ACTIVE_LOW;
      deb_cnt   <= '0;
      hold_cnt  <= '0;
      o_level   <= 1'b0;
      o_press   <= 1'b0;
      o_release <= 1'b0;
      o_long    <= 1'b0;
      o_repeat  <= 1'b0;
      o_state   <= ST_RELEASED;
    end else begin
      // Stage p0/p1: metastability filter on the raw pin
      sync_p0   <= i_btn;
      sync_p1   <= sync_p0;

      // Debounce: level flips only after DEB_CYC consecutive disagreeing cycles
      o_press   <= rise;
      o_release <= fall;
      if (s == o_level) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        deb_cnt <= '0;
        o_level <= ~o_level;
      end else begin
        deb_cnt <= deb_cnt + DEB_W'(1);
      end

      // Hold FSM: a release in the same cycle wins over a pending long/repeat
      o_long   <= 1'b0;
      o_repeat <= 1'b0;
      case (o_state)
        ST_RELEASED: begin
          hold_cnt <= '0;
          if (rise) o_state <= ST_HELD;
        end
        ST_HELD: begin
          if (fall) begin
            o_state  <= ST_RELEASED;
            hold_cnt <= '0;
          end else if (hold_cnt == LONG_LAST) begin
            o_long   <= 1'b1;
            o_state  <= ST_LONG;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        ST_LONG: begin
          if (fall) begin
            o_state  <= ST_RELEASED;
            hold_cnt <= '0;
          end else if (hold_cnt == REP_LAST) begin
            o_repeat <= 1'b1;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        default: begin
          o_state  <= ST_RELEASED;
          hold_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: an active-low and an active-high instance checked
// every cycle against a run-length / time-since-press behavioural model.
module tb_button_conditioner;

  localparam int DEB  = 4;
  localparam int LONG = 20;
  localparam int REP  = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_a = 1'b1;
  logic       btn_b = 1'b0;
  logic       level_a, press_a, release_a, long_a, repeat_a;
  logic       level_b, press_b, release_b, long_b, repeat_b;
  logic [1:0] state_a, state_b;

  always #5 clk = ~clk;

  button_conditioner #(.DEB_CYC(DEB), .LONG_CYC(LONG), .REP_CYC(REP), .ACTIVE_LOW(1'b1)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_btn(btn_a),
    .o_level(level_a), .o_press(press_a), .o_release(release_a),
    .o_long(long_a), .o_repeat(repeat_a), .o_state(state_a)
  );

  button_conditioner #(.DEB_CYC(DEB), .LONG_CYC(LONG), .REP_CYC(REP), .ACTIVE_LOW(1'b0)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_btn(btn_b),
    .o_level(level_b), .o_press(press_b), .o_release(release_b),
    .o_long(long_b), .o_repeat(repeat_b), .o_state(state_b)
  );

  wire [6:0] act_a = {level_a, press_a, release_a, long_a, repeat_a, state_a};
  wire [6:0] act_b = {level_b, press_b, release_b, long_b, repeat_b, state_b};

  int checks = 0;
  int failures = 0;

  // Model state per instance (0 = active-low, 1 = active-high), all in "pressed" terms
  bit         m_d0[2], m_d1[2], m_level[2];
  bit         m_press[2], m_release[2], m_long[2], m_repeat[2];
  int         m_run[2], m_held[2];
  logic [1:0] m_state[2];

  function automatic logic [6:0] exp_vec(int i);
    return {m_level[i], m_press[i], m_release[i], m_long[i], m_repeat[i], m_state[i]};
  endfunction

  // Advance one clock: the model sees exactly what the DUT samples at this edge.
  task automatic tick();
    bit raw[2];
    bit synced;
    @(posedge clk);
    raw[0] = ~btn_a;
    raw[1] = btn_b;
    for (int i = 0; i < 2; i++) begin
      m_press[i] = 0; m_release[i] = 0; m_long[i] = 0; m_repeat[i] = 0;
      if (rst) begin
        m_d0[i] = 0; m_d1[i] = 0; m_level[i] = 0;
        m_run[i] = 0; m_held[i] = 0; m_state[i] = 2'd0;
      end else begin
        synced  = m_d1[i];
        m_d1[i] = m_d0[i];
        m_d0[i] = raw[i];
        m_run[i] = (synced != m_level[i]) ? m_run[i] + 1 : 0;
        if (m_run[i] == DEB) begin
          m_run[i]   = 0;
          m_level[i] = ~m_level[i];
          if (m_level[i]) begin
            m_press[i] = 1;
            m_held[i]  = 0;
          end else begin
            m_release[i] = 1;
          end
        end else if (m_level[i]) begin
          m_held[i]++;
          if (m_held[i] == LONG) m_long[i] = 1;
          else if (m_held[i] > LONG && (m_held[i] - LONG) % REP == 0) m_repeat[i] = 1;
        end
        m_state[i] = !m_level[i] ? 2'd0 : (m_held[i] >= LONG ? 2'd2 : 2'd1);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    int pulses_b = 0;
    rst = 1'b1; btn_a = 1'b1; btn_b = 1'b0;
    repeat (3) tick();
    checks++;
    if (act_a !== 7'd0) begin failures++; $display("FAIL reset_a: got %b expected %b", act_a, 7'd0); end
    checks++;
    if (act_b !== 7'd0) begin failures++; $display("FAIL reset_b: got %b expected %b", act_b, 7'd0); end
    rst = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      pulses_b += press_b + release_b + long_b + repeat_b;
      checks++;
      if ({act_a, act_b} !== {exp_vec(0), exp_vec(1)})
        begin failures++; $display("FAIL after_reset c=%0d: got %b expected %b", c, {act_a, act_b}, {exp_vec(0), exp_vec(1)}); end
    end
    checks++;
    if (pulses_b != 0) begin failures++; $display("FAIL poweron_b_pulses: got %0d expected 0", pulses_b); end
  endtask

  task automatic test_clean_press();
    int press_c = -1, long_c = -1, rep1 = -1, rep2 = -1, rels = 0;
    btn_a = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      tick();
      if (press_a && press_c < 0) press_c = c;
      if (long_a && long_c < 0) long_c = c;
      if (repeat_a) begin
        if (rep1 < 0) rep1 = c;
        else if (rep2 < 0) rep2 = c;
      end
      checks++;
      if ({act_a, act_b} !== {exp_vec(0), exp_vec(1)})
        begin failures++; $display("FAIL clean_press c=%0d: got %b expected %b", c, {act_a, act_b}, {exp_vec(0), exp_vec(1)}); end
    end
    checks++;
    if (press_c != 6) begin failures++; $display("FAIL press_latency: got %0d expected 6", press_c); end
    checks++;
    if (long_c != 26) begin failures++; $display("FAIL long_time: got %0d expected 26", long_c); end
    checks++;
    if (rep1 != 34 || rep2 != 42) begin failures++; $display("FAIL repeat_times: got %0d,%0d expected 34,42", rep1, rep2); end
    btn_a = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      rels += release_a;
      checks++;
      if ({act_a, act_b} !== {exp_vec(0), exp_vec(1)})
        begin failures++; $display("FAIL clean_release c=%0d: got %b expected %b", c, {act_a, act_b}, {exp_vec(0), exp_vec(1)}); end
    end
    checks++;
    if (rels != 1 || state_a !== 2'd0) begin failures++; $display("FAIL clean_release_count: got %0d/%0d expected 1/0", rels, state_a); end
  endtask

  task automatic test_bounce();
    int pulses = 0, lvl = 0;
    for (int c = 0; c < 40; c++) begin
      btn_a = (c < 30) ? (((c / 3) % 2) != 0) : 1'b1;
      tick();
      pulses += press_a + release_a + long_a + repeat_a;
      lvl    += level_a;
      checks++;
      if ({act_a, act_b} !== {exp_vec(0), exp_vec(1)})
        begin failures++; $display("FAIL bounce c=%0d: got %b expected %b", c, {act_a, act_b}, {exp_vec(0), exp_vec(1)}); end
    end
    checks++;
    if (pulses != 0 || lvl != 0) begin failures++; $display("FAIL bounce_quiet: got pulses=%0d level_cycles=%0d expected 0/0", pulses, lvl); end
  endtask

  task automatic test_short_press();
    int press_c = -1, rel_c = -1, longs = 0, presses = 0, rels = 0;
    for (int c = 1; c <= 30; c++) begin
      if (c == 1) btn_a = 1'b0;
      if (c == 11) btn_a = 1'b1;
      tick();
      if (press_a) begin presses++; press_c = c; end
      if (release_a) begin rels++; rel_c = c; end
      longs += long_a + repeat_a;
      checks++;
      if ({act_a, act_b} !== {exp_vec(0), exp_vec(1)})
        begin failures++; $display("FAIL short_press c=%0d: got %b expected %b", c, {act_a, act_b}, {exp_vec(0), exp_vec(1)}); end
    end
    checks++;
    if (presses != 1 || rels != 1 || rel_c - press_c != 10 || longs != 0 || state_a !== 2'd0)
      begin failures++; $display("FAIL short_press_summary: got p=%0d r=%0d gap=%0d long=%0d st=%0d expected 1 1 10 0 0", presses, rels, rel_c - press_c, longs, state_a); end
  endtask

  task automatic test_long_boundary();
    int press_c = -1, rel_c = -1, longs = 0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 1) btn_a = 1'b0;
      if (c == 21) btn_a = 1'b1;
      tick();
      if (press_a) press_c = c;
      if (release_a) rel_c = c;
      longs += long_a + repeat_a;
      checks++;
      if ({act_a, act_b} !== {exp_vec(0), exp_vec(1)})
        begin failures++; $display("FAIL long_boundary c=%0d: got %b expected %b", c, {act_a, act_b}, {exp_vec(0), exp_vec(1)}); end
    end
    checks++;
    if (press_c != 6 || rel_c != 26 || longs != 0)
      begin failures++; $display("FAIL long_boundary_summary: got press=%0d rel=%0d long=%0d expected 6 26 0", press_c, rel_c, longs); end
  endtask

  task automatic test_reset_mid_long();
    int press_c = -1, rels = 0;
    btn_a = 1'b0;
    repeat (35) tick();
    checks++;
    if (state_a !== 2'd2) begin failures++; $display("FAIL mid_long_state: got %0d expected 2", state_a); end
    rst = 1'b1;
    tick();
    checks++;
    if (act_a !== 7'd0 || act_b !== 7'd0) begin failures++; $display("FAIL mid_long_reset: got %b %b expected 0", act_a, act_b); end
    rst = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (press_a && press_c < 0) press_c = c;
      rels += release_a;
      checks++;
      if ({act_a, act_b} !== {exp_vec(0), exp_vec(1)})
        begin failures++; $display("FAIL after_mid_reset c=%0d: got %b expected %b", c, {act_a, act_b}, {exp_vec(0), exp_vec(1)}); end
    end
    checks++;
    if (press_c != 6 || rels != 0) begin failures++; $display("FAIL redetect: got press=%0d releases=%0d expected 6 0", press_c, rels); end
    btn_a = 1'b1;
    repeat (12) tick();
  endtask

  task automatic test_active_high();
    int press_c = -1;
    btn_b = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (press_b && press_c < 0) press_c = c;
      checks++;
      if ({act_a, act_b} !== {exp_vec(0), exp_vec(1)})
        begin failures++; $display("FAIL active_high c=%0d: got %b expected %b", c, {act_a, act_b}, {exp_vec(0), exp_vec(1)}); end
    end
    checks++;
    if (press_c != 6) begin failures++; $display("FAIL active_high_latency: got %0d expected 6", press_c); end
    btn_b = 1'b0;
    repeat (12) tick();
  endtask

  task automatic test_random();
    int left_a = 0, left_b = 0;
    for (int c = 0; c < 3000; c++) begin
      if (left_a == 0) begin btn_a = $urandom_range(0, 1); left_a = $urandom_range(1, 32); end
      if (left_b == 0) begin btn_b = $urandom_range(0, 1); left_b = $urandom_range(1, 32); end
      left_a--; left_b--;
      rst = ($urandom_range(0, 299) == 0);
      tick();
      checks++;
      if ({act_a, act_b} !== {exp_vec(0), exp_vec(1)})
        begin failures++; $display("FAIL random c=%0d: got %b expected %b", c, {act_a, act_b}, {exp_vec(0), exp_vec(1)}); end
      checks++;
      if ($countones({press_a, release_a, long_a, repeat_a}) > 1 || $countones({press_b, release_b, long_b, repeat_b}) > 1)
        begin failures++; $display("FAIL pulse_exclusive c=%0d: got %b %b expected at most one", c, act_a, act_b); end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_short_press();
    test_long_boundary();
    test_reset_mid_long();
    test_active_high();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
